sound_cmd_mailbox: RTL

- Buffers the 68k→Z80 sound command path and the Z80→68k reply path, and sequences the Z80 NMI that announces each command.
- Sits beside the Z80 controller decode in the sound I/O domain.
- Consumes the controller's nSDZ80R/nSDZ80W/nSDZ80CLR strobes and drives nZ80NMI.
- Commands are queued in a small FIFO so back-to-back 68k writes are not lost while the Z80 services an earlier NMI.

---
 rtl/sound_cmd_mailbox.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sound_cmd_mailbox.sv
// Sound command mailbox: 68k->Z80 command FIFO with NMI sequencing, and a
// single-entry Z80->68k reply latch. Z80 strobes arrive asynchronously and
// act on their rising (end-of-access) edge after synchronisation.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no NMI pending; waits for enable and a queued command
// ASSERT | nZ80NMI held low until the Z80 reads the command port
// GAP    | nZ80NMI held high NMI_GAP cycles so the next NMI is a new edge
module sound_cmd_mailbox #(
    parameter int FIFO_DEPTH = 4,
    parameter int NMI_GAP    = 8
) (
    input  logic                          CLK,
    input  logic                          nRESET,
    input  logic                          M68K_CMD_WR,
    input  logic [7:0]                    M68K_DATA_IN,
    input  logic                          M68K_REPLY_RD,
    output logic [7:0]                    M68K_REPLY,
    output logic                          REPLY_VALID,
    input  logic                          nSDZ80R,
    input  logic                          nSDZ80W,
    input  logic                          nSDZ80CLR,
    input  logic [7:0]                    SDD_IN,
    output logic [7:0]                    SDD_OUT,
    input  logic                          NMI_EN_SET,
    input  logic                          NMI_EN_CLR,
    output logic                          nZ80NMI,
    output logic [$clog2(FIFO_DEPTH):0]   CMD_COUNT,
    output logic                          CMD_OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(NMI_GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_GAP
    } state_t;

    // bit 0: nSDZ80R, bit 1: nSDZ80W, bit 2: nSDZ80CLR
    logic [2:0]    strobe_s1;
    logic [2:0]    strobe_s2;
    logic [2:0]    strobe_d;
    logic [2:0]    strobe_rise;
    logic          rd_rise;
    logic          wr_rise;
    logic          clr_rise;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [CW-1:0] count_q;
    logic [7:0]    head_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          do_pop;
    logic          do_push;

    logic [7:0]    capture_q;
    logic          nmi_en_q;
    logic          nmi_en_nxt;
    state_t        state;
    logic [GW-1:0] gap_cnt;

    // Two-flop synchronisers plus a delayed copy for end-of-strobe detection
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            strobe_s1 <= '1;
            strobe_s2 <= '1;
            strobe_d  <= '1;
        end else begin
            strobe_s1 <= {nSDZ80CLR, nSDZ80W, nSDZ80R};
            strobe_s2 <= strobe_s1;
            strobe_d  <= strobe_s2;
        end
    end

    assign strobe_rise = strobe_s2 & ~strobe_d;
    assign rd_rise     = strobe_rise[0];
    assign wr_rise     = strobe_rise[1];
    assign clr_rise    = strobe_rise[2];

    // A pop frees a slot first, so a push into a full queue in the same cycle fits
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign do_pop     = rd_rise && !fifo_empty;
    assign do_push    = M68K_CMD_WR && (!fifo_full || do_pop);
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    // Queue storage needs no reset; validity is tracked by count_q
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= M68K_DATA_IN;
        end
    end

    // Pointers, occupancy, registered head and sticky overflow
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            head_q       <= 8'h00;
            CMD_OVERFLOW <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
            if (do_pop) begin
                if (count_q > CW'(1)) begin
                    head_q <= mem[rd_ptr_nxt];
                end else if (do_push) begin
                    head_q <= M68K_DATA_IN;
                end
            end else if (do_push && fifo_empty) begin
                head_q <= M68K_DATA_IN;
            end
            if (M68K_CMD_WR && !do_push) begin
                CMD_OVERFLOW <= 1'b1;
            end
        end
    end

    assign SDD_OUT   = head_q;
    assign CMD_COUNT = count_q;

    // Clear beats set when both pulse together
    assign nmi_en_nxt = NMI_EN_CLR ? 1'b0 : (NMI_EN_SET ? 1'b1 : nmi_en_q);

    // NMI enable register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            nmi_en_q <= 1'b0;
        end else begin
            nmi_en_q <= nmi_en_nxt;
        end
    end

    // NMI sequencer; the gap exit re-arms directly so the high time is exactly NMI_GAP
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= ST_IDLE;
            nZ80NMI <= 1'b1;
            gap_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (nmi_en_nxt && !fifo_empty) begin
                        state   <= ST_ASSERT;
                        nZ80NMI <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (do_pop || !nmi_en_nxt) begin
                        state   <= ST_GAP;
                        nZ80NMI <= 1'b1;
                        gap_cnt <= GW'(NMI_GAP - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        if (nmi_en_nxt && !fifo_empty) begin
                            state   <= ST_ASSERT;
                            nZ80NMI <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    nZ80NMI <= 1'b1;
                end
            endcase
        end
    end

    // Track the Z80 data bus while its write strobe is low; last value is committed
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            capture_q <= 8'h00;
        end else if (!strobe_s2[1]) begin
            capture_q <= SDD_IN;
        end
    end

    // Reply latch: Z80 write beats clear and beats the 68k read acknowledge
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            M68K_REPLY  <= 8'h00;
            REPLY_VALID <= 1'b0;
        end else if (wr_rise) begin
            M68K_REPLY  <= capture_q;
            REPLY_VALID <= 1'b1;
        end else if (clr_rise) begin
            M68K_REPLY  <= 8'h00;
            REPLY_VALID <= 1'b0;
        end else if (M68K_REPLY_RD) begin
            REPLY_VALID <= 1'b0;
        end
    end

endmodule
